// File: rtl/block_spawn_scheduler.sv
// rtl/block_spawn_scheduler.sv - beat-driven falling-block spawn sequencer with four-slot allocation
// Optional overflow lane FIFO is built when SPAWN_FIFO_EN is defined.
module block_spawn_scheduler #(
    parameter int NUM_SLOTS  = 4,
    parameter int LAST_BEAT  = 95,
    parameter int FIRST_BEAT = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 restart,
    input  logic                 pause,
    input  logic [1:0]           level,
    input  logic [6:0]           beat_cnt,
    input  logic [NUM_SLOTS-1:0] slot_done,
    output logic                 spawn_valid,
    output logic [1:0]           spawn_slot,
    output logic [1:0]           spawn_lane,
    output logic [NUM_SLOTS-1:0] slot_busy,
    output logic [7:0]           drop_cnt,
    output logic                 end_game
);

    localparam logic [6:0] FIRST_B = 7'(FIRST_BEAT);
    localparam logic [6:0] LAST_B  = 7'(LAST_BEAT);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    state_t               state_q, state_d;
    logic [6:0]           pre_beat_q;
    logic [NUM_SLOTS-1:0] busy_q, busy_d;
    logic                 spawn_valid_q, spawn_valid_d;
    logic [1:0]           spawn_slot_q, spawn_slot_d;
    logic [1:0]           spawn_lane_q, spawn_lane_d;
    logic [7:0]           drop_q, drop_d;
    logic                 end_game_q, end_game_d;

    logic       advance, spawn_en, step_hit, req;
    logic       have_free, issue, drop, fifo_empty;
    logic [1:0] free_idx, req_lane, issue_lane;

    assign advance  = beat_cnt > pre_beat_q;
    assign spawn_en = (state_q == RUN) && !pause;
    assign req_lane = beat_cnt[2:1];

    always_comb begin
        step_hit = 1'b0;
        case (level)
            2'd0:    step_hit = (beat_cnt % 7'd6) == 7'd0;
            2'd1:    step_hit = beat_cnt[1:0] == 2'd0;
            default: step_hit = beat_cnt[0] == 1'b0;
        endcase
    end

    assign req = advance && spawn_en && step_hit &&
                 (beat_cnt >= FIRST_B) && (beat_cnt <= LAST_B);

    // Registered busy only: a slot finishing this cycle is not reusable until next cycle.
    always_comb begin
        have_free = 1'b0;
        free_idx  = 2'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                have_free = 1'b1;
                free_idx  = 2'(i);
            end
        end
    end

`ifdef SPAWN_FIFO_EN
    logic [1:0] fifo_mem_q [4];
    logic [1:0] rd_q, rd_d, wr_q, wr_d;
    logic [2:0] cnt_q, cnt_d;
    logic       pop, push, push_ok;

    // Pending requests keep priority so lanes come out in arrival order.
    always_comb begin
        pop        = spawn_en && (cnt_q != 3'd0) && have_free;
        push       = req && ((cnt_q != 3'd0) || !have_free);
        push_ok    = push && (cnt_q != 3'd4);
        drop       = push && (cnt_q == 3'd4);
        issue      = pop || (req && (cnt_q == 3'd0) && have_free);
        issue_lane = pop ? fifo_mem_q[rd_q] : req_lane;
        fifo_empty = cnt_q == 3'd0;
        rd_d       = pop ? rd_q + 2'd1 : rd_q;
        wr_d       = push_ok ? wr_q + 2'd1 : wr_q;
        cnt_d      = cnt_q + 3'(push_ok) - 3'(pop);
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem_q[wr_q] <= req_lane;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= 2'd0;
            wr_q  <= 2'd0;
            cnt_q <= 3'd0;
        end else if (restart) begin
            rd_q  <= 2'd0;
            wr_q  <= 2'd0;
            cnt_q <= 3'd0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        issue      = req && have_free;
        drop       = req && !have_free;
        issue_lane = req_lane;
        fifo_empty = 1'b1;
    end
`endif

    always_comb begin
        busy_d        = busy_q & ~slot_done;
        spawn_valid_d = 1'b0;
        spawn_slot_d  = spawn_slot_q;
        spawn_lane_d  = spawn_lane_q;
        drop_d        = drop_q;
        state_d       = state_q;

        if (issue) begin
            spawn_valid_d    = 1'b1;
            spawn_slot_d     = free_idx;
            spawn_lane_d     = issue_lane;
            busy_d[free_idx] = 1'b1;
        end
        if (drop && (drop_q != 8'hff)) drop_d = drop_q + 8'd1;

        case (state_q)
            IDLE:   if (advance) state_d = RUN;
            RUN: begin
                if (pause)
                    state_d = PAUSED;
                else if ((beat_cnt > LAST_B) && (busy_q == '0) && fifo_empty)
                    state_d = DONE;
            end
            PAUSED: if (!pause) state_d = RUN;
            DONE:   state_d = DONE;
            default: state_d = IDLE;
        endcase

        end_game_d = state_d == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pre_beat_q    <= 7'd0;
            busy_q        <= '0;
            spawn_valid_q <= 1'b0;
            spawn_slot_q  <= 2'd0;
            spawn_lane_q  <= 2'd0;
            drop_q        <= 8'd0;
            end_game_q    <= 1'b0;
        end else if (restart) begin
            state_q       <= IDLE;
            pre_beat_q    <= 7'd0;
            busy_q        <= '0;
            spawn_valid_q <= 1'b0;
            spawn_slot_q  <= 2'd0;
            spawn_lane_q  <= 2'd0;
            drop_q        <= 8'd0;
            end_game_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pre_beat_q    <= beat_cnt;
            busy_q        <= busy_d;
            spawn_valid_q <= spawn_valid_d;
            spawn_slot_q  <= spawn_slot_d;
            spawn_lane_q  <= spawn_lane_d;
            drop_q        <= drop_d;
            end_game_q    <= end_game_d;
        end
    end

    assign spawn_valid = spawn_valid_q;
    assign spawn_slot  = spawn_slot_q;
    assign spawn_lane  = spawn_lane_q;
    assign slot_busy   = busy_q;
    assign drop_cnt    = drop_q;
    assign end_game    = end_game_q;

endmodule

// File: tb/tb_block_spawn_scheduler.sv
// tb/tb_block_spawn_scheduler.sv - scoreboard bench for block_spawn_scheduler
module tb_block_spawn_scheduler;

    logic       clk = 1'b0;
    logic       rst_n, restart, pause;
    logic [1:0] level;
    logic [6:0] beat_cnt;
    logic [3:0] slot_done;
    logic       spawn_valid;
    logic [1:0] spawn_slot, spawn_lane;
    logic [3:0] slot_busy;
    logic [7:0] drop_cnt;
    logic       end_game;

    int n_total = 0;
    int n_bad   = 0;

    logic [3:0] exp_q [$];
    logic [3:0] mon_exp;

    block_spawn_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .restart     (restart),
        .pause       (pause),
        .level       (level),
        .beat_cnt    (beat_cnt),
        .slot_done   (slot_done),
        .spawn_valid (spawn_valid),
        .spawn_slot  (spawn_slot),
        .spawn_lane  (spawn_lane),
        .slot_busy   (slot_busy),
        .drop_cnt    (drop_cnt),
        .end_game    (end_game)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Expected entries are {slot, lane}.
    always @(negedge clk) begin
        if (rst_n && spawn_valid) begin
            if (exp_q.size() == 0) begin
                check("spawn_unexpected", 32'(spawn_valid), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("spawn_slot_lane", {28'd0, spawn_slot, spawn_lane}, {28'd0, mon_exp});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_spawn(input logic [1:0] slot, input logic [1:0] lane);
        exp_q.push_back({slot, lane});
    endtask

    task automatic step_beats(input int from, input int to);
        for (int b = from; b <= to; b++) begin
            beat_cnt = 7'(b);
            tick();
            tick();
        end
    endtask

    task automatic do_restart();
        restart   = 1'b1;
        beat_cnt  = 7'd0;
        pause     = 1'b0;
        slot_done = 4'd0;
        tick();
        tick();
        restart = 1'b0;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(spawn_valid), 32'd0);
        check({tag, "_slot"},  32'(spawn_slot),  32'd0);
        check({tag, "_lane"},  32'(spawn_lane),  32'd0);
        check({tag, "_busy"},  32'(slot_busy),   32'd0);
        check({tag, "_drop"},  32'(drop_cnt),    32'd0);
        check({tag, "_end"},   32'(end_game),    32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        restart   = 1'b0;
        pause     = 1'b0;
        level     = 2'd0;
        beat_cnt  = 7'd0;
        slot_done = 4'd0;
        tick();
        tick();
        rst_n = 1'b1;
        check_reset_outputs("rst");

        // Level 0: spawns at beats 6, 12, 18 into slots 0..2.
        step_beats(1, 5);
        expect_spawn(2'd0, 2'd3);
        beat_cnt = 7'd6;
        tick();
        check("lat_valid", 32'(spawn_valid), 32'd1);
        check("lat_busy", 32'(slot_busy), 32'h1);
        tick();
        check("pulse_one_cycle", 32'(spawn_valid), 32'd0);
        expect_spawn(2'd1, 2'd2);
        expect_spawn(2'd2, 2'd1);
        step_beats(7, 18);
        tick();
        check("l0_busy", 32'(slot_busy), 32'h7);
        check("l0_drop", 32'(drop_cnt), 32'd0);
        check("l0_sb_empty", 32'(exp_q.size()), 32'd0);

        // Level 2: four spawns fill every slot, beats 14 and 16 overflow.
        do_restart();
        level = 2'd2;
        expect_spawn(2'd0, 2'd3);
        expect_spawn(2'd1, 2'd0);
        expect_spawn(2'd2, 2'd1);
        expect_spawn(2'd3, 2'd2);
        step_beats(1, 16);
        tick();
        check("l2_busy", 32'(slot_busy), 32'hf);
`ifdef SPAWN_FIFO_EN
        check("l2_drop", 32'(drop_cnt), 32'd0);
`else
        check("l2_drop", 32'(drop_cnt), 32'd2);
`endif
        check("l2_sb_empty", 32'(exp_q.size()), 32'd0);

        // Freeing slot 2 with requests outstanding.
`ifdef SPAWN_FIFO_EN
        expect_spawn(2'd2, 2'd3);
`endif
        slot_done = 4'b0100;
        tick();
        slot_done = 4'd0;
        check("free2_busy", 32'(slot_busy), 32'hb);
        check("free2_no_spawn_yet", 32'(spawn_valid), 32'd0);
        tick();
`ifdef SPAWN_FIFO_EN
        check("pop_valid", 32'(spawn_valid), 32'd1);
        check("pop_slot", 32'(spawn_slot), 32'd2);
        check("pop_busy", 32'(slot_busy), 32'hf);
`else
        check("nofifo_valid", 32'(spawn_valid), 32'd0);
        check("nofifo_busy", 32'(slot_busy), 32'hb);
`endif
        tick();
        tick();
        check("free2_sb_empty", 32'(exp_q.size()), 32'd0);

        // Same-cycle done on slot 0 and a new request: slot 1 must be used.
        do_restart();
        check("restart_drop", 32'(drop_cnt), 32'd0);
        level = 2'd0;
        expect_spawn(2'd0, 2'd3);
        step_beats(1, 11);
        check("same_pre_busy", 32'(slot_busy), 32'h1);
        expect_spawn(2'd1, 2'd2);
        beat_cnt  = 7'd12;
        slot_done = 4'b0001;
        tick();
        slot_done = 4'd0;
        check("same_valid", 32'(spawn_valid), 32'd1);
        check("same_slot", 32'(spawn_slot), 32'd1);
        check("same_busy", 32'(slot_busy), 32'h2);
        tick();
        check("same_sb_empty", 32'(exp_q.size()), 32'd0);

        // Pause discards beats 12 and 18; next spawn at 24.
        do_restart();
        level = 2'd0;
        expect_spawn(2'd0, 2'd3);
        step_beats(1, 11);
        pause = 1'b1;
        step_beats(12, 18);
        check("pause_busy", 32'(slot_busy), 32'h1);
        pause = 1'b0;
        tick();
        tick();
        expect_spawn(2'd1, 2'd0);
        step_beats(19, 24);
        tick();
        check("resume_busy", 32'(slot_busy), 32'h3);
        check("resume_drop", 32'(drop_cnt), 32'd0);
        check("resume_sb_empty", 32'(exp_q.size()), 32'd0);

        // Song over: end_game follows the last slot clear by one cycle.
        beat_cnt = 7'd96;
        tick();
        tick();
        tick();
        check("end_while_busy", 32'(end_game), 32'd0);
        slot_done = 4'b0011;
        tick();
        slot_done = 4'd0;
        check("end_busy_clear", 32'(slot_busy), 32'd0);
        check("end_not_yet", 32'(end_game), 32'd0);
        tick();
        check("end_rise", 32'(end_game), 32'd1);
        tick();
        check("end_hold", 32'(end_game), 32'd1);
        check("end_slot_before_restart", 32'(spawn_slot), 32'd1);

        restart = 1'b1;
        tick();
        check_reset_outputs("restart");
        restart = 1'b0;
        tick();
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/block_spawn_scheduler.md
# block_spawn_scheduler

Sequences falling-block spawns for the piano game's four lanes. It detects beat advances on `beat_cnt`, decides from the level-dependent chart rule whether a block is due, and allocates one of four falling-block slots (the per-block height datapaths) to that block. Slots are returned when their datapath reports done. The block sits between the beat counter and the slot datapaths, and raises `end_game` when the song is over and the playfield is empty.

## Interface
Parameters:
- `NUM_SLOTS`, 4: number of falling-block datapath slots; fixed at 4 in this revision.
- `LAST_BEAT`, 95: final beat that may spawn a block.
- `FIRST_BEAT`, 6: first beat that may spawn a block.

Ports:
- `clk` in 1: system clock, the same clock that drives the slot datapaths.
- `rst_n` in 1: asynchronous, active-low reset.
- `restart` in 1: synchronous clear; same effect as reset, applied on the next clock edge.
- `pause` in 1: freezes spawning while high; beats that arrive while paused are discarded.
- `level` in 2: difficulty level; sets the spawn step.
- `beat_cnt` in 7: beat count from the beat counter; monotonic between restarts.
- `slot_done` in 4: one-cycle pulses, one per slot; the slot's block was hit or left the screen.
- `spawn_valid` out 1: one-cycle pulse that loads a slot.
- `spawn_slot` out 2: index of the slot being loaded; valid with `spawn_valid`.
- `spawn_lane` out 2: lane of the spawned block; valid with `spawn_valid`.
- `slot_busy` out 4: occupancy bitmap of the slots.
- `drop_cnt` out 8: count of lost spawn requests; saturates at 255.
- `end_game` out 1: level-high once the song is finished and all slots are free.

## Operation
- State machine states: IDLE, RUN, PAUSED, DONE.
  - IDLE to RUN on the first beat advance.
  - RUN to PAUSED while `pause`=1; PAUSED to RUN when `pause`=0.
  - RUN to DONE when `beat_cnt` > `LAST_BEAT`, `slot_busy`=0 and no request is pending.
  - DONE is held until reset or `restart`.
- Beat advance: `beat_cnt` > `pre_beat`, where `pre_beat` is a registered copy of `beat_cnt`.
  - `pre_beat` resets to 0.
  - A `beat_cnt` that decreases is not an advance and only reloads `pre_beat`.
- Spawn rule, checked on a beat advance in RUN only:
  - A request is raised when `FIRST_BEAT` <= `beat_cnt` <= `LAST_BEAT` and `beat_cnt` mod step == 0.
  - Step is 6 for level 0, 4 for level 1, and 2 for levels 2 and 3.
  - Request lane = `beat_cnt[2:1]`.
- Allocation: the lowest-index slot with `slot_busy`=0 wins.
  - `slot_busy[i]` is set in the cycle `spawn_valid` issues for slot i.
  - `slot_busy[i]` is cleared on `slot_done[i]`.
- Simultaneous `slot_done[i]` and a request in the same cycle: slot i is not free for that cycle.
  - Allocation uses the registered `slot_busy`, so it picks another free slot or follows the no-free-slot rule.
- `slot_done` for a slot that is not busy is ignored.
- No free slot: behaviour is set by `SPAWN_FIFO_EN` (see Configuration).
- DONE: new requests are ignored; `slot_done` still clears busy bits.

## Timing
- Reset and `restart` values:
  - state = IDLE, `slot_busy`=0, `drop_cnt`=0.
  - `spawn_valid`=0, `spawn_slot`=0, `spawn_lane`=0, `end_game`=0, `pre_beat`=0.
  - FIFO is empty.
- Latency: `beat_cnt` changes at edge N, so the advance is seen combinationally in cycle N.
  - `spawn_valid` is a registered pulse, high for the cycle after edge N+1.
  - `slot_busy` updates at the same edge.
- At most one spawn is issued per cycle.
- A FIFO pop has priority over a new request.
  - A new request that arrives while the FIFO is non-empty is pushed, which preserves order.
- `end_game` is registered and rises one cycle after the DONE condition holds.
- `restart` held high keeps the block in its reset values. The block resumes in IDLE on the first edge after `restart` falls.

## Configuration
- `SPAWN_FIFO_EN` defined:
  - A 4-entry lane FIFO holds requests that find no free slot.
  - The FIFO pops into the first slot that frees, with `spawn_valid` one cycle after the `slot_done` edge.
  - A push when the FIFO is full increments `drop_cnt`.
  - The DONE condition additionally requires the FIFO to be empty.
- `SPAWN_FIFO_EN` undefined:
  - A request with no free slot is dropped immediately and `drop_cnt` increments.
  - No FIFO storage is built.

## Test plan
- Reset, level=0, `beat_cnt` stepped 0..18: spawns only at beats 6, 12 and 18.
  - Lanes are 3, 2 and 1.
  - Slots are 0, 1 and 2, assuming no `slot_done`.
- level=2, no `slot_done`, beats 6..16:
  - Spawns at beats 6, 8, 10 and 12 fill slots 0..3.
  - Beats 14 and 16 are handled by the macro setting:
    - FIFO build: both are queued and `drop_cnt`=0.
    - No-FIFO build: `drop_cnt`=2.
- FIFO build, full slots plus 2 queued: pulse `slot_done[2]` → `spawn_slot`=2 with the oldest lane, one cycle later.
- Same-cycle `slot_done[0]` and a request, slot 1 free → request lands in slot 1; `slot_busy[0]` clears.
- `pause`=1 across beats 12 and 18 at level 0 → no spawns. Release `pause` → next spawn at beat 24.
- `beat_cnt` set to 96, then `slot_done` pulsed for all busy slots → `end_game`=1 one cycle after the last clear.
  - Asserting `restart` afterwards returns all outputs to their reset values.
